sr_latch_driver: RTL

//  Initiator side of the gated SR latch interface: turns raw pushbutton set/clear requests into

---
 rtl/sr_latch_driver.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//  Initiator for a gated SR latch. Raw set/clear requests are synchronized and
//  edge-detected. Each accepted request becomes a single S or R pulse with a
//  matching gate strobe. The latch Q is then read back to confirm the write.
//
//  Parameters
//   SYNC_STAGES  flops per input synchronizer (>= 2)
//   PULSE_W      cycles S_out/R_out/gate stay high per command (1..255)
//   TIMEOUT      CHECK cycles allowed for q_fb to match the target (1..255)
//
//  Ports
//   Clk, Reset         clock, asynchronous active-high reset
//   set_req, clr_req   raw asynchronous requests, active-high
//   q_fb               latch Q feedback, asynchronous
//   S_out, R_out, gate latch drive; gate is high exactly while S_out or R_out is high
//   busy               high whenever the FSM is not in IDLE
//   done               one-cycle pulse: write confirmed
//   conflict           one-cycle pulse: set and clear edges seen in the same cycle
//   err                sticky confirmation failure, cleared by the next accepted command
//   q_state            last confirmed latch value
//
//  Build option
//   SR_AUTO_RETRY_EN   when defined, the first CHECK timeout re-issues one full
//                      pulse with the same target; a second timeout is an error.
module sr_latch_driver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic S_out,
    output logic R_out,
    output logic gate,
    output logic busy,
    output logic done,
    output logic conflict,
    output logic err,
    output logic q_state
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Input synchronizers and edge history
    logic [SYNC_STAGES-1:0] set_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] q_sync;
    logic                   set_prev;
    logic                   clr_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            set_sync <= '0;
            clr_sync <= '0;
            q_sync   <= '0;
            set_prev <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            set_sync <= {set_sync[SYNC_STAGES-2:0], set_req};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_req};
            q_sync   <= {q_sync[SYNC_STAGES-2:0], q_fb};
            set_prev <= set_sync[SYNC_STAGES-1];
            clr_prev <= clr_sync[SYNC_STAGES-1];
        end
    end

    logic set_edge_c;
    logic clr_edge_c;
    logic q_fb_s_c;

    assign set_edge_c = set_sync[SYNC_STAGES-1] & ~set_prev;
    assign clr_edge_c = clr_sync[SYNC_STAGES-1] & ~clr_prev;
    assign q_fb_s_c   = q_sync[SYNC_STAGES-1];

    // FSM state and datapath registers
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             target;
    logic             target_d;
    logic             err_d;
    logic             q_state_d;
    logic             done_d;
    logic             conflict_d;
    logic             drive_d;
    logic             s_d;
    logic             r_d;
    logic             busy_d;
`ifdef SR_AUTO_RETRY_EN
    logic             retry_used;
    logic             retry_used_d;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            target   <= 1'b0;
            S_out    <= 1'b0;
            R_out    <= 1'b0;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            conflict <= 1'b0;
            err      <= 1'b0;
            q_state  <= 1'b0;
`ifdef SR_AUTO_RETRY_EN
            retry_used <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            target   <= target_d;
            S_out    <= s_d;
            R_out    <= r_d;
            gate     <= drive_d;
            busy     <= busy_d;
            done     <= done_d;
            conflict <= conflict_d;
            err      <= err_d;
            q_state  <= q_state_d;
`ifdef SR_AUTO_RETRY_EN
            retry_used <= retry_used_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs follow the next state so they
    // line up with the state they belong to.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        target_d   = target;
        err_d      = err;
        q_state_d  = q_state;
        done_d     = 1'b0;
        conflict_d = 1'b0;
`ifdef SR_AUTO_RETRY_EN
        retry_used_d = retry_used;
`endif

        case (state)
            IDLE: begin
                if (set_edge_c && clr_edge_c) begin
                    conflict_d = 1'b1;
                end else if (set_edge_c || clr_edge_c) begin
                    state_d  = DRIVE;
                    target_d = set_edge_c;
                    cnt_d    = CNT_W'(PULSE_W);
                    err_d    = 1'b0;
`ifdef SR_AUTO_RETRY_EN
                    retry_used_d = 1'b0;
`endif
                end
            end

            DRIVE: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(TIMEOUT);
                end
            end

            CHECK: begin
                if (q_fb_s_c == target) begin
                    done_d    = 1'b1;
                    q_state_d = target;
                    state_d   = IDLE;
                end else if (cnt <= CNT_W'(1)) begin
`ifdef SR_AUTO_RETRY_EN
                    if (!retry_used) begin
                        state_d      = DRIVE;
                        cnt_d        = CNT_W'(PULSE_W);
                        retry_used_d = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
`else
                    state_d = ERROR;
`endif
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end

            ERROR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // S and R are derived from one drive flag so they can never overlap
        drive_d = (state_d == DRIVE);
        s_d     = drive_d & target_d;
        r_d     = drive_d & ~target_d;
        busy_d  = (state_d != IDLE);
    end

endmodule
